// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and slice helper for the multi-port register file
// Purpose: default widths and the mapping from a port index to the low bit
//          of that port's slice in a flattened port vector.
// Ports:   none (package).
package regfile_pkg;

   localparam int DW_DEF = 32;
   localparam int AW_DEF = 5;

   // Port idx of width bits occupies [slice_lo(idx, width) +: width].
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/claim bus of the multi-port register file
// Purpose: bundles the decode/writeback side signals of regfile_mp.
// Ports:   master (datapath) drives rd_addr, we, wa, wd, claim, claim_addr and
//          receives rd_data, rd_busy, busy_vec; slave (register file) is the mirror.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int AW  = AW_DEF,
   parameter int NRD = 2,
   parameter int NWR = 2
);
   localparam int DEPTH = 2 ** AW;

   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic [NWR-1:0]    we;
   logic [NWR*AW-1:0] wa;
   logic [NWR*DW-1:0] wd;
   logic              claim;
   logic [AW-1:0]     claim_addr;
   logic [DEPTH-1:0]  busy_vec;

   modport master (
      output rd_addr, we, wa, wd, claim, claim_addr,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  rd_addr, we, wa, wd, claim, claim_addr,
      output rd_data, rd_busy, busy_vec
   );

endinterface

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one combinational read port with write-through bypass
// Purpose: returns the stored register value, or the same-cycle write data of
//          the highest-index write port hitting the address; masks busy on a hit.
// Ports:   rst (forces zero outputs), addr, reg_data/reg_busy (stored state at
//          addr), we/wa/wd (write ports), data/busy (port outputs).
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int NWR      = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              rst,
   input  logic [AW-1:0]     addr,
   input  logic [DW-1:0]     reg_data,
   input  logic              reg_busy,
   input  logic [NWR-1:0]    we,
   input  logic [NWR*AW-1:0] wa,
   input  logic [NWR*DW-1:0] wd,
   output logic [DW-1:0]     data,
   output logic              busy
);

   logic hit;

   always_comb begin
      data = reg_data;
      hit  = 1'b0;
      // Ascending scan: the last matching port (highest index) wins.
      for (int j = 0; j < NWR; j++) begin
         if (we[j] && (wa[slice_lo(j, AW) +: AW] == addr)) begin
            hit  = 1'b1;
            data = wd[slice_lo(j, DW) +: DW];
         end
      end
      // A pending result is being delivered right now, so it is no longer busy.
      busy = reg_busy && !hit;
      // Reset must also hide the bypass path; r0 never bypasses when hardwired.
      if (rst || (ZERO_REG && (addr == '0))) begin
         data = '0;
         busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with busy scoreboard
// Purpose: DEPTH x DW registers, NRD bypassed read ports, NWR prioritised write
//          ports and a per-register busy bit (set by claim, cleared by write).
// Ports:   clk, rst (async, active-high), bus (regfile_mp_if.slave).
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0]    gpr_q [DEPTH];
   logic [DW-1:0]    gpr_d [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   always_comb begin
      gpr_d  = gpr_q;
      busy_d = busy_q;
      // Ascending scan: on an address collision the highest-index port wins.
      for (int j = 0; j < NWR; j++) begin
         if (bus.we[j]) begin
            gpr_d[bus.wa[slice_lo(j, AW) +: AW]]  = bus.wd[slice_lo(j, DW) +: DW];
            busy_d[bus.wa[slice_lo(j, AW) +: AW]] = 1'b0;
         end
      end
      // Applied after the writes so a same-cycle claim leaves the register busy.
      if (bus.claim) begin
         busy_d[bus.claim_addr] = 1'b1;
      end
      // Hardwired r0 simply discards any write or claim aimed at it.
      if (ZERO_REG) begin
         gpr_d[0]  = '0;
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpr_q  <= '{default: '0};
         busy_q <= '0;
      end else begin
         gpr_q  <= gpr_d;
         busy_q <= busy_d;
      end
   end

   assign bus.busy_vec = busy_q;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          busy;

      assign addr = bus.rd_addr[slice_lo(i, AW) +: AW];

      regfile_rdport #(
         .DW       (DW),
         .AW       (AW),
         .NWR      (NWR),
         .ZERO_REG (ZERO_REG)
      ) u_rdport (
         .rst      (rst),
         .addr     (addr),
         .reg_data (gpr_q[addr]),
         .reg_busy (busy_q[addr]),
         .we       (bus.we),
         .wa       (bus.wa),
         .wd       (bus.wd),
         .data     (data),
         .busy     (busy)
      );

      assign bus.rd_data[slice_lo(i, DW) +: DW] = data;
      assign bus.rd_busy[i]                     = busy;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp (default and swept parameters)
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   regfile_mp_if #(.DW(32), .AW(5), .NRD(2), .NWR(2)) bus_a ();
   regfile_mp_if #(.DW(16), .AW(3), .NRD(4), .NWR(1)) bus_b ();

   regfile_mp #(.DW(32), .AW(5), .NRD(2), .NWR(2), .ZERO_REG(1'b1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   regfile_mp #(.DW(16), .AW(3), .NRD(4), .NWR(1), .ZERO_REG(1'b0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        cl;
      logic [4:0]  ca;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] xd0;
      logic [31:0] xd1;
      logic        xb0;
      logic        xb1;
      logic [31:0] xbv;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1, input logic cl,
                               input logic [4:0] ca, input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic [31:0] xd0, input logic [31:0] xd1, input logic xb0,
                               input logic xb1, input logic [31:0] xbv);
      vec_t v;
      v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
      v.cl = cl; v.ca = ca; v.ra0 = ra0; v.ra1 = ra1;
      v.xd0 = xd0; v.xd1 = xd1; v.xb0 = xb0; v.xb1 = xb1; v.xbv = xbv;
      return v;
   endfunction

   function automatic logic [15:0] val_b(input int i);
      return 16'hA000 + 16'(i * 16'h0111);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive_a(input vec_t v);
      bus_a.we         = v.we;
      bus_a.wa         = {v.wa1, v.wa0};
      bus_a.wd         = {v.wd1, v.wd0};
      bus_a.claim      = v.cl;
      bus_a.claim_addr = v.ca;
      bus_a.rd_addr    = {v.ra1, v.ra0};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int addrs[2][4];
      addrs[0] = '{0, 3, 5, 7};
      addrs[1] = '{6, 4, 2, 1};

      //            we     wa0    wd0           wa1    wd1           cl    ca     ra0    ra1    xd0           xd1           xb0   xb1   xbv
      vecs[0]  = mk(2'b01, 5'd3,  32'h12345678, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd3,  32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0);
      vecs[1]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd9,  32'h12345678, 32'h0,        1'b0, 1'b0, 32'h0);
      vecs[2]  = mk(2'b11, 5'd9,  32'h1111,     5'd9,  32'h2222,     1'b0, 5'd0,  5'd9,  5'd3,  32'h2222,     32'h12345678, 1'b0, 1'b0, 32'h0);
      vecs[3]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h2222,     32'h2222,     1'b0, 1'b0, 32'h0);
      vecs[4]  = mk(2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
      vecs[5]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd3,  32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0);
      vecs[6]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd4,  5'd4,  5'd4,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
      vecs[7]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd4,  32'h0,        32'h0,        1'b1, 1'b1, 32'h10);
      vecs[8]  = mk(2'b10, 5'd0,  32'h0,        5'd4,  32'hA5A5A5A5, 1'b0, 5'd0,  5'd4,  5'd5,  32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 32'h10);
      vecs[9]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd4,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
      vecs[10] = mk(2'b01, 5'd4,  32'h0BADF00D, 5'd0,  32'h0,        1'b1, 5'd4,  5'd4,  5'd9,  32'h0BADF00D, 32'h2222,     1'b0, 1'b0, 32'h0);
      vecs[11] = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd9,  32'h0BADF00D, 32'h2222,     1'b1, 1'b0, 32'h10);
      vecs[12] = mk(2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        1'b1, 5'd7,  5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h10);
      vecs[13] = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 32'h90);
      vecs[14] = mk(2'b11, 5'd10, 32'hAAAA,     5'd11, 32'hBBBB,     1'b0, 5'd0,  5'd10, 5'd11, 32'hAAAA,     32'hBBBB,     1'b0, 1'b0, 32'h90);
      vecs[15] = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd10, 5'd11, 32'hAAAA,     32'hBBBB,     1'b0, 1'b0, 32'h90);

      drive_a(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9,
                 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
      bus_b.we = '0; bus_b.wa = '0; bus_b.wd = '0;
      bus_b.claim = 1'b0; bus_b.claim_addr = '0; bus_b.rd_addr = '0;

      // Reset state.
      @(negedge clk); #1;
      chk("reset a busy_vec", bus_a.busy_vec, 32'h0);
      chk("reset a rd_data0", bus_a.rd_data[31:0], 32'h0);
      chk("reset b busy_vec", {24'h0, bus_b.busy_vec}, 32'h0);
      rst = 1'b0;

      // Vector table: drive at negedge, sample just after, edge commits.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive_a(vecs[i]);
         #1;
         chk($sformatf("v%0d rd_data0", i), bus_a.rd_data[31:0], vecs[i].xd0);
         chk($sformatf("v%0d rd_data1", i), bus_a.rd_data[63:32], vecs[i].xd1);
         chk($sformatf("v%0d rd_busy0", i), {31'h0, bus_a.rd_busy[0]}, {31'h0, vecs[i].xb0});
         chk($sformatf("v%0d rd_busy1", i), {31'h0, bus_a.rd_busy[1]}, {31'h0, vecs[i].xb1});
         chk($sformatf("v%0d busy_vec", i), bus_a.busy_vec, vecs[i].xbv);
      end

      // Asynchronous reset mid-cycle with r5 loaded and r7 claimed.
      @(negedge clk);
      drive_a(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7,
                 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
      #1;
      chk("pre-rst r5", bus_a.rd_data[31:0], 32'hDEADBEEF);
      chk("pre-rst busy r7", {31'h0, bus_a.rd_busy[1]}, 32'h1);
      #1;
      rst = 1'b1;
      bus_a.we = 2'b01; bus_a.wa = {5'd0, 5'd5}; bus_a.wd = {32'h0, 32'h55};
      bus_a.claim = 1'b1; bus_a.claim_addr = 5'd6;
      #1;
      chk("rst rd_data0", bus_a.rd_data[31:0], 32'h0);
      chk("rst rd_data1", bus_a.rd_data[63:32], 32'h0);
      chk("rst rd_busy1", {31'h0, bus_a.rd_busy[1]}, 32'h0);
      chk("rst busy_vec", bus_a.busy_vec, 32'h0);
      @(negedge clk); #1;
      chk("rst held rd_data0", bus_a.rd_data[31:0], 32'h0);
      chk("rst held busy_vec", bus_a.busy_vec, 32'h0);
      rst = 1'b0;
      bus_a.we = 2'b00; bus_a.claim = 1'b0;
      bus_a.rd_addr = {5'd3, 5'd5};
      #1;
      chk("post-rst r5", bus_a.rd_data[31:0], 32'h0);
      chk("post-rst r3", bus_a.rd_data[63:32], 32'h0);
      @(negedge clk); #1;
      chk("post-rst busy_vec", bus_a.busy_vec, 32'h0);

      // Parameter sweep instance: fill all eight registers, r0 included.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus_b.we = 1'b1; bus_b.wa = 3'(i); bus_b.wd = val_b(i);
      end
      @(negedge clk);
      bus_b.we = 1'b0;
      for (int s = 0; s < 2; s++) begin
         for (int p = 0; p < 4; p++) bus_b.rd_addr[p*3 +: 3] = 3'(addrs[s][p]);
         #1;
         for (int p = 0; p < 4; p++)
            chk($sformatf("b set%0d port%0d", s, p), {16'h0, bus_b.rd_data[p*16 +: 16]},
                {16'h0, val_b(addrs[s][p])});
         @(negedge clk);
      end

      // Bypass on the single write port, port 3 reading the target.
      bus_b.we = 1'b1; bus_b.wa = 3'd2; bus_b.wd = 16'h5A5A;
      bus_b.rd_addr = {3'd2, 3'd1, 3'd1, 3'd0};
      #1;
      chk("b bypass port3", {16'h0, bus_b.rd_data[63:48]}, 32'h5A5A);
      chk("b r0 port0", {16'h0, bus_b.rd_data[15:0]}, {16'h0, val_b(0)});

      // r0 is an ordinary register here, so it can be claimed.
      @(negedge clk);
      bus_b.we = 1'b0; bus_b.claim = 1'b1; bus_b.claim_addr = 3'd0;
      @(negedge clk);
      bus_b.claim = 1'b0;
      #1;
      chk("b busy_vec r0", {24'h0, bus_b.busy_vec}, 32'h1);
      chk("b rd_busy r0", {31'h0, bus_b.rd_busy[0]}, 32'h1);
      chk("b r2 stored", {16'h0, bus_b.rd_data[63:48]}, 32'h5A5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the multicycle CPU datapath, replacing the single-write, two-read register file. It provides NRD combinational read ports with same-cycle write-through bypass and NWR posedge write ports with fixed priority. A per-register busy scoreboard tracks results still pending from multicycle units. It sits between decode (operand read, busy check) and writeback (result write, busy clear).

## Interface
- DW, 32, data width in bits
- AW, 5, address width; DEPTH = 2**AW registers
- NRD, 2, number of read ports (≥1)
- NWR, 2, number of write ports (≥1)
- ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NRD*DW  read data, combinational
- rd_busy  out  NRD  busy bit of the addressed register, combinational
- we  in  NWR  write enables
- wa  in  NWR*AW  write addresses
- wd  in  NWR*DW  write data
- claim  in  1  mark claim_addr busy (result pending)
- claim_addr  in  AW  register to mark busy
- busy_vec  out  DEPTH  registered scoreboard state

## Operation
- State: gpr[DEPTH] of DW bits; busy[DEPTH] of 1 bit.
- Reset (rst=1, asynchronous): every gpr clears to 0 and every busy bit clears to 0. While rst is high, rd_data = 0, rd_busy = 0, busy_vec = 0. Reset mid-operation discards pending writes and claims.
- Write: on posedge, each port j with we[j]=1 writes wd[j] into gpr[wa[j]] and clears busy[wa[j]].
- Write collision: when several ports target the same address, the highest-index port wins. No error is flagged.
- Claim: on posedge with claim=1, busy[claim_addr] is set. If a write targets the same address in the same cycle, the claim wins: data is written and busy ends at 1.
- Read: rd_data[i] = gpr[rd_addr[i]], except as below.
  - Bypass: if any we[j] is set with wa[j] == rd_addr[i], rd_data[i] = wd[j] from the highest such j.
  - rd_busy[i] = busy[rd_addr[i]] AND NOT (a same-cycle write hits that address). A same-cycle claim does not affect rd_busy; it becomes visible the next cycle.
- ZERO_REG=1:
  - Writes and claims to address 0 are ignored.
  - Reads of address 0 return 0 with rd_busy=0, and bypass does not apply.
  - busy_vec[0] is always 0.
- No internal FSM beyond the scoreboard bits. Each busy bit is a 2-state machine, FREE→BUSY on claim and BUSY→FREE on write. Simultaneous claim and write resolves to BUSY.

## Timing
- Write latency: data is visible in gpr after one posedge, and visible on rd_data in the same cycle through bypass.
- Read path is purely combinational: rd_addr/we/wa/wd → rd_data, rd_busy.
- busy_vec is a direct register output with no combinational input paths.
- No handshake; the caller holds inputs stable around the posedge.

## Structure
- Package regfile_pkg holds the DW/AW defaults and the function that maps a port index to a bit slice.
- Sub-module regfile_rdport holds one read port: address-match bypass priority mux plus busy masking. It is instantiated NRD times via generate.
- The write-priority and claim logic lives in regfile_mp.

## Test plan
- Reset: preload r5=0xDEADBEEF and claim r7, then pulse rst asynchronously mid-cycle → all reads return 0 immediately, busy_vec=0.
- Basic plus bypass: we[0]=1, wa=3, wd=0x12345678 with rd_addr[1]=3 in the same cycle → rd_data[1]=0x12345678 before the edge; the value is held after the edge with we=0.
- Collision: we[0]=we[1]=1, wa both 9, wd=0x1111/0x2222 → rd_data=0x2222 same cycle; gpr[9]=0x2222 after the edge.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 and claim r0 → rd_data=0, rd_busy=0, busy_vec[0]=0.
- Scoreboard:
  - Claim r4 → rd_busy for r4=1 from the next cycle.
  - Write r4 → rd_busy=0 in the same cycle, busy_vec[4]=0 after the edge.
  - Claim and write r4 in the same cycle → busy_vec[4]=1 and gpr[4] updated.
- Parameter sweep: DW=16, AW=3, NRD=4, NWR=1, ZERO_REG=0 → r0 is writable; four simultaneous reads of distinct registers return correct data.
